// File: rtl/alarm_output_driver.sv
// Alarm annunciator: registers the request code, runs an IDLE/ALERT/EMERG/HOLD FSM
// and drives a blinking LED pair plus a gated square-wave buzzer.
module alarm_output_driver #(
   parameter int unsigned TONE_DIV    = 25000,
   parameter int unsigned BLINK_DIV   = 12500000,
   parameter int unsigned HOLD_BLINKS = 4
) (
   input  logic       CLK_ROSHI,
   input  logic       reset,
   input  logic [2:0] Z,
   output logic       buzzer,
   output logic       led_alerta,
   output logic       led_emergencia,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ALERT = 2'b01,
      EMERG = 2'b10,
      HOLD  = 2'b11
   } state_t;

   localparam logic [31:0] TONE_LAST  = 32'(TONE_DIV - 1);
   localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);
   localparam logic [31:0] HOLD_LAST  = 32'(HOLD_BLINKS - 1);

   state_t      state_reg;
   state_t      state_next;
   logic [2:0]  z_q;
   logic [31:0] blink_cnt;
   logic [31:0] tone_cnt;
   logic [31:0] hold_cnt;
   logic        blink_phase;
   logic        tone;
   logic        held_emerg;
   logic        blink_wrap;
   logic        tone_wrap;
   logic        entering;
   logic        tone_clear;

   assign blink_wrap = (blink_cnt == BLINK_LAST);
   assign tone_wrap  = (tone_cnt == TONE_LAST);
   assign entering   = (state_next != state_reg) && (state_next != IDLE);
   assign tone_clear = entering && ((state_next == ALERT) || (state_next == EMERG));
   assign state      = state_reg;

   // Next state and outputs; emergency bit always wins over the alert bit.
   always_comb begin
      state_next     = state_reg;
      buzzer         = 1'b0;
      led_alerta     = 1'b0;
      led_emergencia = 1'b0;
      case (state_reg)
         IDLE: begin
            if (z_q[0])
               state_next = EMERG;
            else if (z_q[1])
               state_next = ALERT;
         end
         ALERT: begin
            led_alerta = blink_phase;
            buzzer     = tone & z_q[2];
            if (z_q[0])
               state_next = EMERG;
            else if (z_q[1:0] == 2'b00)
               state_next = HOLD;
         end
         EMERG: begin
            led_emergencia = 1'b1;
            buzzer         = tone & z_q[2] & blink_phase;
            if (z_q[1:0] == 2'b00)
               state_next = HOLD;
         end
         HOLD: begin
            if (held_emerg)
               led_emergencia = 1'b1;
            else
               led_alerta = blink_phase;
            if (z_q[0])
               state_next = EMERG;
            else if (z_q[1])
               state_next = ALERT;
            else if (blink_wrap && (hold_cnt == HOLD_LAST))
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK_ROSHI or posedge reset) begin
      if (reset) begin
         z_q        <= 3'b000;
         state_reg  <= IDLE;
         held_emerg <= 1'b0;
      end else begin
         z_q       <= Z;
         state_reg <= state_next;
         if (state_next == EMERG)
            held_emerg <= 1'b1;
         else if (state_next == ALERT)
            held_emerg <= 1'b0;
      end
   end

   // Blink and hold counters restart on every entry into an active state.
   always_ff @(posedge CLK_ROSHI or posedge reset) begin
      if (reset) begin
         blink_cnt   <= 32'd0;
         blink_phase <= 1'b1;
         hold_cnt    <= 32'd0;
      end else if (entering) begin
         blink_cnt   <= 32'd0;
         blink_phase <= 1'b1;
         hold_cnt    <= 32'd0;
      end else begin
         if (blink_wrap) begin
            blink_cnt   <= 32'd0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 32'd1;
         end
         if ((state_reg == HOLD) && blink_wrap)
            hold_cnt <= hold_cnt + 32'd1;
      end
   end

   always_ff @(posedge CLK_ROSHI or posedge reset) begin
      if (reset) begin
         tone_cnt <= 32'd0;
         tone     <= 1'b0;
      end else if (tone_clear) begin
         tone_cnt <= 32'd0;
         tone     <= 1'b0;
      end else if (tone_wrap) begin
         tone_cnt <= 32'd0;
         tone     <= ~tone;
      end else begin
         tone_cnt <= tone_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_alarm_output_driver.sv
// Scoreboard bench for alarm_output_driver with small dividers: stimulus queues
// edge-stamped expectations, a negedge monitor pops and compares them.
module tb_alarm_output_driver;

   logic       clk;
   logic       reset;
   logic [2:0] Z;
   logic       buzzer;
   logic       led_alerta;
   logic       led_emergencia;
   logic [1:0] state;

   alarm_output_driver #(
      .TONE_DIV   (4),
      .BLINK_DIV  (16),
      .HOLD_BLINKS(2)
   ) dut (
      .CLK_ROSHI     (clk),
      .reset         (reset),
      .Z             (Z),
      .buzzer        (buzzer),
      .led_alerta    (led_alerta),
      .led_emergencia(led_emergencia),
      .state         (state)
   );

   typedef struct {
      int         cyc;
      logic [1:0] st;
      logic       buz;
      logic       la;
      logic       le;
      string      nm;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   edges = 0;
   int   t;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   // Expectations are kept ordered by edge stamp.
   task automatic push_exp(input int cyc, input logic [1:0] st, input logic b,
                           input logic la, input logic le, input string nm);
      exp_t e;
      int   i;
      e = '{cyc, st, b, la, le, nm};
      i = 0;
      while (i < sb.size() && sb[i].cyc <= cyc) i++;
      sb.insert(i, e);
   endtask

   task automatic advance_to(input int stamp);
      while (edges < stamp) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= edges) begin
            e = sb.pop_front();
            tests++;
            if (e.cyc < edges) begin
               fails++;
               $display("[TB] FAIL %s: check for edge %0d missed (now edge %0d)", e.nm, e.cyc, edges);
            end else if (state !== e.st || buzzer !== e.buz || led_alerta !== e.la ||
                         led_emergencia !== e.le) begin
               fails++;
               $display("[TB] FAIL %s @edge %0d: got st=%b buz=%b la=%b le=%b, want st=%b buz=%b la=%b le=%b",
                        e.nm, edges, state, buzzer, led_alerta, led_emergencia,
                        e.st, e.buz, e.la, e.le);
            end else begin
               $display("[TB] ok %s @edge %0d: st=%b buz=%b la=%b le=%b",
                        e.nm, edges, state, buzzer, led_alerta, led_emergencia);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      reset = 1'b1;
      Z     = 3'b000;
      @(posedge clk);
      #2;
      push_exp(edges, 2'b00, 0, 0, 0, "reset_state");
      advance_to(edges + 2);
      reset = 1'b0;

      // Sound request alone never leaves IDLE
      t = edges;
      Z = 3'b100;
      push_exp(t + 2, 2'b00, 0, 0, 0, "sound_only_idle_a");
      push_exp(t + 4, 2'b00, 0, 0, 0, "sound_only_idle_b");
      advance_to(t + 5);

      // Alert with sound: two-edge latency, 16-clock blink, 4-clock tone
      t = edges;
      Z = 3'b110;
      push_exp(t + 1,  2'b00, 0, 0, 0, "alert_latency");
      push_exp(t + 2,  2'b01, 0, 1, 0, "alert_entry");
      push_exp(t + 5,  2'b01, 0, 1, 0, "tone_low_end");
      push_exp(t + 6,  2'b01, 1, 1, 0, "tone_high");
      push_exp(t + 10, 2'b01, 0, 1, 0, "tone_low_again");
      push_exp(t + 17, 2'b01, 1, 1, 0, "blink_on_last");
      push_exp(t + 18, 2'b01, 0, 0, 0, "blink_off");
      push_exp(t + 22, 2'b01, 1, 0, 0, "tone_in_blink_off");
      push_exp(t + 34, 2'b01, 0, 1, 0, "blink_on_again");
      advance_to(t + 38);

      // Silence while tone is high
      t = edges;
      Z = 3'b010;
      push_exp(t + 1,  2'b01, 0, 1, 0, "silence_next_edge");
      push_exp(t + 2,  2'b01, 0, 1, 0, "silence_held");
      push_exp(t + 12, 2'b01, 0, 0, 0, "blink_uninterrupted");
      advance_to(t + 12);

      // Escalate to emergency: chirped buzzer only during blink-on
      t = edges;
      Z = 3'b101;
      push_exp(t + 1,  2'b01, 0, 0, 0, "pre_emerg");
      push_exp(t + 2,  2'b10, 0, 0, 1, "emerg_entry");
      push_exp(t + 6,  2'b10, 1, 0, 1, "chirp_on");
      push_exp(t + 10, 2'b10, 0, 0, 1, "chirp_tone_low");
      push_exp(t + 17, 2'b10, 1, 0, 1, "chirp_last_on");
      push_exp(t + 22, 2'b10, 0, 0, 1, "chirp_gated_off");
      push_exp(t + 38, 2'b10, 1, 0, 1, "chirp_resumes");
      advance_to(t + 40);

      // Clear requests: HOLD for two blink half-periods, then IDLE
      t = edges;
      Z = 3'b000;
      push_exp(t + 1,  2'b10, 0, 0, 1, "emerg_silenced");
      push_exp(t + 2,  2'b11, 0, 0, 1, "hold_entry");
      push_exp(t + 18, 2'b11, 0, 0, 1, "hold_mid");
      push_exp(t + 33, 2'b11, 0, 0, 1, "hold_last");
      push_exp(t + 34, 2'b00, 0, 0, 0, "hold_to_idle");
      advance_to(t + 36);

      // Alert-severity HOLD, re-alert from HOLD, then time out to IDLE
      t = edges;
      Z = 3'b010;
      push_exp(t + 2, 2'b01, 0, 1, 0, "alert_from_idle");
      advance_to(t + 4);
      Z = 3'b000;
      push_exp(t + 5,  2'b01, 0, 1, 0, "alert_before_hold");
      push_exp(t + 6,  2'b11, 0, 1, 0, "hold_alert_entry");
      push_exp(t + 22, 2'b11, 0, 0, 0, "hold_alert_blink");
      advance_to(t + 24);
      Z = 3'b010;
      push_exp(t + 25, 2'b11, 0, 0, 0, "hold_before_realert");
      push_exp(t + 26, 2'b01, 0, 1, 0, "hold_to_alert");
      advance_to(t + 28);
      Z = 3'b000;
      push_exp(t + 30, 2'b11, 0, 1, 0, "hold_alert_again");
      push_exp(t + 61, 2'b11, 0, 0, 0, "hold_alert_last");
      push_exp(t + 62, 2'b00, 0, 0, 0, "hold_alert_idle");
      advance_to(t + 64);

      // Emergency priority with all bits set
      t = edges;
      Z = 3'b111;
      push_exp(t + 1, 2'b00, 0, 0, 0, "prio_latency");
      push_exp(t + 2, 2'b10, 0, 0, 1, "emerg_priority");
      push_exp(t + 6, 2'b10, 1, 0, 1, "prio_chirp");
      advance_to(t + 7);

      // Asynchronous reset pulse between clock edges while buzzer is high
      reset = 1'b1;
      Z     = 3'b000;
      push_exp(edges, 2'b00, 0, 0, 0, "async_reset");
      #4;
      reset = 1'b0;
      advance_to(edges + 1);
      t = edges;
      push_exp(t + 2, 2'b00, 0, 0, 0, "post_reset_idle_a");
      push_exp(t + 6, 2'b00, 0, 0, 0, "post_reset_idle_b");
      advance_to(t + 6);

      for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         tests++;
         fails++;
         $display("[TB] FAIL %s: never checked (stamp edge %0d)", e.nm, e.cyc);
      end
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
